// File: rtl/mdu_unit_if.sv
// Handshake and result bundle between the E-stage decode logic and the multiply/divide unit.
// The master drives the request side; the slave (mdu_unit) drives busy, HI, LO and mdu_out.
interface mdu_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mdu_out;

  modport master (
    output start, mdu_op, A, B,
    input  busy, HI, LO, mdu_out
  );

  modport slave (
    input  start, mdu_op, A, B,
    output busy, HI, LO, mdu_out
  );
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit with HI/LO registers: fixed-latency mult/multu/div/divu,
// single-cycle mthi/mtlo and a combinational mfhi/mflo read port.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_is_arith;
  logic             w_is_mult_req;
  logic             w_accept;
  logic             w_commit;
  logic             w_op_is_div;
  logic             w_signed_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [31:0]      w_a_mag;
  logic [31:0]      w_b_mag;
  logic [63:0]      w_prod_mag;
  logic [63:0]      w_prod;
  logic             w_div_by_zero;
  logic [31:0]      w_quo_mag;
  logic [31:0]      w_rem_mag;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic [CNT_W-1:0] w_load_cnt;

  // Request decode
  assign w_is_arith    = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);
  assign w_is_mult_req = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
  assign w_accept      = (r_state == S_IDLE) && bus.start && w_is_arith;
  assign w_commit      = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
  assign w_load_cnt    = w_is_mult_req ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  // Signed ops are reduced to unsigned magnitudes; the magnitude of 0x80000000 is
  // itself as an unsigned value, so the most-negative operand needs no special case.
  assign w_op_is_div   = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_signed_op   = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_a_neg       = w_signed_op && r_a[31];
  assign w_b_neg       = w_signed_op && r_b[31];
  assign w_a_mag       = w_a_neg ? (~r_a + 32'd1) : r_a;
  assign w_b_mag       = w_b_neg ? (~r_b + 32'd1) : r_b;

  assign w_prod_mag    = {32'd0, w_a_mag} * {32'd0, w_b_mag};
  assign w_prod        = (w_a_neg ^ w_b_neg) ? (~w_prod_mag + 64'd1) : w_prod_mag;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_div_by_zero = (r_b == 32'd0);
  assign w_quo_mag     = w_div_by_zero ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_rem_mag     = w_div_by_zero ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_quo         = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
  assign w_rem         = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= w_load_cnt;
            r_op    <= bus.mdu_op;
            r_a     <= bus.A;
            r_b     <= bus.B;
          end else if (!bus.start) begin
            if (bus.mdu_op == OP_MTHI) begin
              r_hi <= bus.A;
            end else if (bus.mdu_op == OP_MTLO) begin
              r_lo <= bus.A;
            end
          end
        end
        S_RUN: begin
          if (w_commit) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (!w_op_is_div) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (!w_div_by_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

  always_comb begin
    bus.mdu_out = 32'd0;
    if (bus.mdu_op == OP_MFHI) begin
      bus.mdu_out = r_hi;
    end else if (bus.mdu_op == OP_MFLO) begin
      bus.mdu_out = r_lo;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: a cycle-numbered reference model checked every cycle, plus
// directed vectors with hand-computed literal results.
module tb_mdu_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mdu_unit_if bus();

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {valid, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = 65'd0;
    case (op)
      OP_MULT:  begin p = sa * sb; ref_result = {1'b1, p}; end
      OP_MULTU: begin p = ua * ub; ref_result = {1'b1, p}; end
      OP_DIV:   if (b != 32'd0) begin
                  sq = sa / sb;
                  sr = sa % sb;
                  ref_result = {1'b1, sr[31:0], sq[31:0]};
                end
      OP_DIVU:  if (b != 32'd0) begin
                  p = ua % ub;
                  ref_result[64:32] = {1'b1, p[31:0]};
                  p = ua / ub;
                  ref_result[31:0] = p[31:0];
                end
      default:  ref_result = 65'd0;
    endcase
  endfunction

  // Model: an accepted op at edge number t commits at edge number t+N
  logic        m_pend = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [64:0] m_res = 65'd0;
  int          m_cyc = 0;
  int          m_commit_at = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend      <= 1'b0;
      m_hi        <= 32'd0;
      m_lo        <= 32'd0;
      m_res       <= 65'd0;
      m_cyc       <= 0;
      m_commit_at <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_pend) begin
        if (m_cyc == m_commit_at) begin
          m_pend <= 1'b0;
          if (m_res[64]) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end
        end
      end else if (bus.start && bus.mdu_op >= OP_MULT && bus.mdu_op <= OP_DIVU) begin
        m_pend      <= 1'b1;
        m_commit_at <= m_cyc + ((bus.mdu_op <= OP_MULTU) ? MULT_N : DIV_N);
        m_res       <= ref_result(bus.mdu_op, bus.A, bus.B);
      end else if (!bus.start && bus.mdu_op == OP_MTHI) begin
        m_hi <= bus.A;
      end else if (!bus.start && bus.mdu_op == OP_MTLO) begin
        m_lo <= bus.A;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_pend});
      check("cyc_hi", bus.HI, m_hi);
      check("cyc_lo", bus.LO, m_lo);
      check("cyc_mdu_out", bus.mdu_out,
            (bus.mdu_op == OP_MFHI) ? m_hi : (bus.mdu_op == OP_MFLO) ? m_lo : 32'd0);
    end
  end

  task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #2;
    bus.start  = st;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = b;
  endtask

  // Issue one op, then count busy cycles until it drops (bounded)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cnt);
    drive(1'b1, op, a, b);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else break;
    end
    $display("op=%0d A=0x%08h B=0x%08h busy_cycles=%0d HI=0x%08h LO=0x%08h",
             op, a, b, cnt, bus.HI, bus.LO);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.start  = 1'b0;
    bus.mdu_op = OP_NONE;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, cnt);
    check("mult_cycles", cnt, 32'd5);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);
    drive(1'b0, OP_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("mfhi_out", bus.mdu_out, 32'hFFFF_FFFF);
    drive(1'b0, OP_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("mflo_out", bus.mdu_out, 32'hFFFF_FFFA);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, cnt);
    check("multu_cycles", cnt, 32'd5);
    check("multu_hi", bus.HI, 32'd1);
    check("multu_lo", bus.LO, 32'hFFFF_FFFE);

    run_op(OP_DIVU, 32'd100, 32'd7, cnt);
    check("divu_cycles", cnt, 32'd10);
    check("divu_hi", bus.HI, 32'd2);
    check("divu_lo", bus.LO, 32'd14);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cnt);
    check("div_neg_hi", bus.HI, 32'hFFFF_FFFF);
    check("div_neg_lo", bus.LO, 32'hFFFF_FFFD);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cnt);
    check("div_ovf_hi", bus.HI, 32'd0);
    check("div_ovf_lo", bus.LO, 32'h8000_0000);

    drive(1'b0, OP_MTHI, 32'h11, 32'd0);
    drive(1'b0, OP_MTLO, 32'h22, 32'd0);
    run_op(OP_DIV, 32'd5, 32'd0, cnt);
    check("div0_cycles", cnt, 32'd10);
    check("div0_hi", bus.HI, 32'h11);
    check("div0_lo", bus.LO, 32'h22);

    // Non-arithmetic op codes with start must not launch anything
    drive(1'b1, 4'd9, 32'd1, 32'd1);
    drive(1'b1, OP_MFHI, 32'd1, 32'd1);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    @(negedge clk);
    check("bad_start_busy", {31'd0, bus.busy}, 32'd0);

    drive(1'b0, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    drive(1'b0, OP_MTLO, 32'h1234_5678, 32'd0);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_hi", bus.HI, 32'hDEAD_BEEF);
    check("mtlo_lo", bus.LO, 32'h1234_5678);
    check("mt_busy", {31'd0, bus.busy}, 32'd0);

    // Second start on the 2nd busy cycle must be ignored
    drive(1'b1, OP_MULT, 32'd2, 32'd2);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else break;
      if (i == 0) drive(1'b1, OP_MULT, 32'd9, 32'd9);
      if (i == 1) drive(1'b0, OP_NONE, 32'd0, 32'd0);
    end
    $display("op=1 A=0x00000002 B=0x00000002 (restart ignored) busy_cycles=%0d HI=0x%08h LO=0x%08h",
             cnt, bus.HI, bus.LO);
    check("restart_cycles", cnt, 32'd5);
    check("restart_hi", bus.HI, 32'd0);
    check("restart_lo", bus.LO, 32'd4);

    // Asynchronous reset two cycles into a MULT
    drive(1'b1, OP_MULT, 32'd3, 32'd4);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_hi", bus.HI, 32'd0);
    check("arst_lo", bus.LO, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    $display("reset mid-run: busy=%0d HI=0x%08h LO=0x%08h", bus.busy, bus.HI, bus.LO);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("post_rst_hi", bus.HI, 32'd0);
    check("post_rst_lo", bus.LO, 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
